fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the decode-signal generator.
- Owns the PC and drives the synchronous instruction ROM.
- Registers the returned word and splits it into opcode/ALUop/register/immediate fields; opcode and ALUop feed decode directly.
- Supports a downstream stall and a PC redirect for jumps and taken branches.

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding the decode-signal generator.
// Owns the PC, addresses a synchronous instruction ROM (one-cycle read
// latency), registers the returned word and slices it into decode fields.
// A downstream stall freezes the stage. A redirect squashes the in-flight
// fetch and restarts at a new target.
module fetch_stage #(
  parameter int                  PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,        // asynchronous, active-low
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] address_imem,
  input  logic [31:0]         q_imem,
  output logic                valid,
  output logic [31:0]         insn,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [4:0]          opcode,
  output logic [4:0]          rd,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          shamt,
  output logic [4:0]          ALUop,
  output logic [31:0]         imm
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // fetch_pc: address to present to the ROM on the next advancing cycle.
  // resp_pc / resp_valid: which address the word now on q_imem belongs to,
  // and whether that word is a real fetch (not the post-reset bubble).
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic                resp_valid_q, resp_valid_d;

  // Output stage registers.
  logic                valid_q, valid_d;
  logic [31:0]         insn_q, insn_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;

  // ROM address mux: redirect beats stall beats advance. During a stall the
  // ROM re-reads resp_pc so q_imem still holds the pending word on release.
  always_comb begin
    address_imem = fetch_pc_q;
    if (redirect) begin
      address_imem = redirect_pc;
    end else if (stall) begin
      address_imem = resp_pc_q;
    end
  end

  // Next-state logic for the fetch pointer, response tracker and output stage.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    valid_d      = valid_q;
    insn_d       = insn_q;
    pc_out_d     = pc_out_q;

    if (redirect) begin
      // The word arriving this cycle belongs to the old path: drop it, keep
      // the last insn/pc_out visible but marked invalid.
      valid_d      = 1'b0;
      resp_pc_d    = redirect_pc;
      resp_valid_d = 1'b1;
      fetch_pc_d   = redirect_pc + PC_ONE;
    end else if (!stall) begin
      insn_d       = q_imem;
      pc_out_d     = resp_pc_q;
      valid_d      = resp_valid_q;
      resp_pc_d    = fetch_pc_q;
      resp_valid_d = 1'b1;
      fetch_pc_d   = fetch_pc_q + PC_ONE;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= '0;
      resp_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      insn_q       <= '0;
      pc_out_q     <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      valid_q      <= valid_d;
      insn_q       <= insn_d;
      pc_out_q     <= pc_out_d;
    end
  end

  // Registered outputs and decode fields sliced straight from insn, so the
  // fields stay stable whenever insn does, regardless of valid.
  always_comb begin
    valid  = valid_q;
    insn   = insn_q;
    pc_out = pc_out_q;
    opcode = insn_q[31:27];
    rd     = insn_q[26:22];
    rs     = insn_q[21:17];
    rt     = insn_q[16:12];
    shamt  = insn_q[11:7];
    ALUop  = insn_q[6:2];
    imm    = {{15{insn_q[16]}}, insn_q[16:0]};
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (RESET_PC=0 and 0xFFE), each
// driving its own one-cycle-latency ROM model.
module tb_fetch_stage;

  logic        clock;
  int          pass_cnt;
  int          total_cnt;

  // Instance A: RESET_PC = 0
  logic        reset_a, stall_a, redirect_a;
  logic [11:0] redirect_pc_a, addr_a, pc_out_a;
  logic [31:0] q_a, insn_a, imm_a;
  logic        valid_a;
  logic [4:0]  opcode_a, rd_a, rs_a, rt_a, shamt_a, aluop_a;

  // Instance B: RESET_PC = 0xFFE
  logic        reset_b, stall_b, redirect_b;
  logic [11:0] redirect_pc_b, addr_b, pc_out_b;
  logic [31:0] q_b, insn_b, imm_b;
  logic        valid_b;
  logic [4:0]  opcode_b, rd_b, rs_b, rt_b, shamt_b, aluop_b;

  fetch_stage #(.PC_WIDTH(12), .RESET_PC(12'h000)) dut_a (
    .clock(clock), .reset(reset_a), .stall(stall_a), .redirect(redirect_a),
    .redirect_pc(redirect_pc_a), .address_imem(addr_a), .q_imem(q_a),
    .valid(valid_a), .insn(insn_a), .pc_out(pc_out_a), .opcode(opcode_a),
    .rd(rd_a), .rs(rs_a), .rt(rt_a), .shamt(shamt_a), .ALUop(aluop_a),
    .imm(imm_a)
  );

  fetch_stage #(.PC_WIDTH(12), .RESET_PC(12'hFFE)) dut_b (
    .clock(clock), .reset(reset_b), .stall(stall_b), .redirect(redirect_b),
    .redirect_pc(redirect_pc_b), .address_imem(addr_b), .q_imem(q_b),
    .valid(valid_b), .insn(insn_b), .pc_out(pc_out_b), .opcode(opcode_b),
    .rd(rd_b), .rs(rs_b), .rt(rt_b), .shamt(shamt_b), .ALUop(aluop_b),
    .imm(imm_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM contents: mem[i] = i*0x01010101, with two special field-test words.
  function automatic logic [31:0] rom_word(input logic [11:0] a);
    logic [31:0] w;
    case (a)
      12'h200: w = 32'h2842_0005;
      12'h201: w = 32'h0001_FFFF;
      default: w = {20'd0, a} * 32'h0101_0101;
    endcase
    return w;
  endfunction

  always @(posedge clock) begin
    q_a <= rom_word(addr_a);
    q_b <= rom_word(addr_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset_a = 1'b0; stall_a = 1'b0; redirect_a = 1'b0; redirect_pc_a = '0;
    reset_b = 1'b0; stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = '0;

    // Reset state
    #2;
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_insn", insn_a, 0);
    chk("rst_pc_out", 32'(pc_out_a), 0);
    chk("rst_opcode", 32'(opcode_a), 0);
    chk("rst_imm", imm_a, 0);
    chk("rst_addr", 32'(addr_a), 0);
    tick();
    tick();
    reset_a = 1'b1;
    #1;
    chk("run_addr0", 32'(addr_a), 0);

    // Free run: valid rises on the second edge
    tick();
    chk("e1_valid", 32'(valid_a), 0);
    chk("e1_addr", 32'(addr_a), 1);
    tick();
    chk("e2_valid", 32'(valid_a), 1);
    chk("e2_insn", insn_a, 32'h0000_0000);
    chk("e2_pc_out", 32'(pc_out_a), 0);
    chk("e2_addr", 32'(addr_a), 2);
    tick();
    chk("e3_insn", insn_a, 32'h0101_0101);
    chk("e3_pc_out", 32'(pc_out_a), 1);
    tick();
    chk("e4_insn", insn_a, 32'h0202_0202);
    chk("e4_pc_out", 32'(pc_out_a), 2);
    tick();
    tick();
    chk("e6_pc_out", 32'(pc_out_a), 4);

    // Stall 3 cycles at pc_out=4
    stall_a = 1'b1;
    #1;
    chk("stall_addr", 32'(addr_a), 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_pc_out", i), 32'(pc_out_a), 4);
      chk($sformatf("stall%0d_insn", i), insn_a, 32'h0404_0404);
      chk($sformatf("stall%0d_valid", i), 32'(valid_a), 1);
    end
    stall_a = 1'b0;
    tick();
    chk("rel_pc5", 32'(pc_out_a), 5);
    chk("rel_insn5", insn_a, 32'h0505_0505);
    tick();
    chk("rel_pc6", 32'(pc_out_a), 6);
    tick();
    chk("rel_pc7", 32'(pc_out_a), 7);
    chk("rel_insn7", insn_a, 32'h0707_0707);

    // Redirect to 0x100 while pc_out=7
    redirect_a = 1'b1;
    redirect_pc_a = 12'h100;
    #1;
    chk("redir_addr", 32'(addr_a), 'h100);
    tick();
    redirect_a = 1'b0;
    chk("redir_valid0", 32'(valid_a), 0);
    chk("redir_pc_hold", 32'(pc_out_a), 7);
    chk("redir_insn_hold", insn_a, 32'h0707_0707);
    #1;
    chk("redir_next_addr", 32'(addr_a), 'h101);
    tick();
    chk("redir_pc100", 32'(pc_out_a), 'h100);
    chk("redir_v100", 32'(valid_a), 1);
    chk("redir_insn100", insn_a, 32'h0101_0100);
    tick();
    chk("redir_pc101", 32'(pc_out_a), 'h101);
    chk("redir_v101", 32'(valid_a), 1);

    // Field decode: redirect to 0x200 where special words live
    redirect_a = 1'b1;
    redirect_pc_a = 12'h200;
    tick();
    redirect_a = 1'b0;
    chk("f_valid0", 32'(valid_a), 0);
    tick();
    chk("f_insn", insn_a, 32'h2842_0005);
    chk("f_opcode", 32'(opcode_a), 5);
    chk("f_rd", 32'(rd_a), 1);
    chk("f_rs", 32'(rs_a), 1);
    chk("f_rt", 32'(rt_a), 0);
    chk("f_shamt", 32'(shamt_a), 0);
    chk("f_aluop", 32'(aluop_a), 1);
    chk("f_imm", imm_a, 32'h0000_0005);
    tick();
    chk("s_insn", insn_a, 32'h0001_FFFF);
    chk("s_imm", imm_a, 32'hFFFF_FFFF);
    chk("s_opcode", 32'(opcode_a), 0);
    chk("s_rt", 32'(rt_a), 'h1F);
    chk("s_shamt", 32'(shamt_a), 'h1F);
    chk("s_aluop", 32'(aluop_a), 'h1F);

    // Redirect and stall together: redirect wins
    redirect_a = 1'b1;
    stall_a = 1'b1;
    redirect_pc_a = 12'h300;
    #1;
    chk("rs_addr", 32'(addr_a), 'h300);
    tick();
    redirect_a = 1'b0;
    stall_a = 1'b0;
    chk("rs_valid0", 32'(valid_a), 0);
    chk("rs_pc_hold", 32'(pc_out_a), 'h201);
    chk("rs_imm_hold", imm_a, 32'hFFFF_FFFF);
    tick();
    chk("rs_pc300", 32'(pc_out_a), 'h300);
    chk("rs_v300", 32'(valid_a), 1);

    // Back-to-back redirects: the last one wins
    redirect_a = 1'b1;
    redirect_pc_a = 12'h050;
    tick();
    chk("bb_valid0a", 32'(valid_a), 0);
    redirect_pc_a = 12'h060;
    tick();
    redirect_a = 1'b0;
    chk("bb_valid0b", 32'(valid_a), 0);
    tick();
    chk("bb_pc060", 32'(pc_out_a), 'h060);
    chk("bb_v060", 32'(valid_a), 1);
    chk("bb_insn060", insn_a, 32'h6060_6060);

    // Instance B: RESET_PC=0xFFE, wraparound
    reset_b = 1'b1;
    #1;
    chk("b_addr0", 32'(addr_b), 'hFFE);
    tick();
    chk("b_e1_valid", 32'(valid_b), 0);
    chk("b_e1_addr", 32'(addr_b), 'hFFF);
    tick();
    chk("b_e2_addr", 32'(addr_b), 'h000);
    chk("b_e2_pc", 32'(pc_out_b), 'hFFE);
    chk("b_e2_valid", 32'(valid_b), 1);
    tick();
    chk("b_e3_pc", 32'(pc_out_b), 'hFFF);
    tick();
    chk("b_e4_pc", 32'(pc_out_b), 'h000);
    chk("b_e4_insn", insn_b, 32'h0000_0000);
    tick();
    chk("b_e5_pc", 32'(pc_out_b), 'h001);
    chk("b_e5_insn", insn_b, 32'h0101_0101);

    // Mid-stream reset clears without waiting for an edge
    reset_b = 1'b0;
    #1;
    chk("b_mrst_valid", 32'(valid_b), 0);
    chk("b_mrst_insn", insn_b, 0);
    chk("b_mrst_pc", 32'(pc_out_b), 0);
    chk("b_mrst_addr", 32'(addr_b), 'hFFE);
    tick();
    reset_b = 1'b1;
    tick();
    chk("b_re1_valid", 32'(valid_b), 0);
    tick();
    chk("b_re2_pc", 32'(pc_out_b), 'hFFE);
    chk("b_re2_valid", 32'(valid_b), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
